// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle processor main FSM, ALU decoder and write-enable gating
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemW,
  output logic       IRWrite,
  output logic       RegW,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic       nowrite_q, nowrite_d;

  logic       next_pc, branch, reg_write, mem_write, ir_write, alu_op;
  logic [3:0] cmd;
  logic       is_cmp;
  logic [1:0] flagw_raw;
  logic       ok;

  assign cmd    = Funct[4:1];
  assign is_cmp = (cmd == 4'b1010);
  assign ok     = ~reset;

  // State and held compare flag; the flag only lives across EXECx -> ALUWB of a data-processing op
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      nowrite_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nowrite_q <= nowrite_d;
    end
  end

  // Next-state logic, plus the rule for what the held compare flag becomes
  always_comb begin
    state_d   = FETCH;
    nowrite_d = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
        nowrite_d = (Op == 2'b00) & is_cmp;
      end
      MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = FETCH;
      EXECR: begin
        state_d   = ALUWB;
        nowrite_d = nowrite_q;
      end
      EXECI: begin
        state_d   = ALUWB;
        nowrite_d = nowrite_q;
      end
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Per-state datapath selects and raw (ungated) enables
  always_comb begin
    next_pc   = 1'b0;
    branch    = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = 1'b1;
        next_pc   = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      EXECR:  alu_op = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB:  reg_write = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder: operation, compare indicator and raw flag enables
  always_comb begin
    ALUControl = 3'b000;
    NoWrite    = 1'b0;
    flagw_raw  = 2'b00;
    if (alu_op) begin
      case (cmd)
        4'b0100: ALUControl = 3'b000;
        4'b0010: ALUControl = 3'b001;
        4'b0000: ALUControl = 3'b010;
        4'b1100: ALUControl = 3'b011;
        4'b1010: begin
          ALUControl = 3'b001;
          NoWrite    = 1'b1;
        end
        default: ALUControl = 3'b000;
      endcase
      if (is_cmp) begin
        flagw_raw = 2'b11;
      end else begin
        flagw_raw[1] = Funct[0];
        flagw_raw[0] = Funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010));
      end
    end
  end

  // Architectural write enables: condition-gated, suppressed for compares, killed during reset
  assign MemW    = ok & mem_write & CondEx;
  assign RegW    = ok & reg_write & CondEx & ~nowrite_q;
  assign PCWrite = ok & (next_pc | (branch & CondEx) |
                         (reg_write & CondEx & (Rd == 4'd15) & ~nowrite_q));
  assign IRWrite = ok & ir_write;
  assign FlagW   = {2{ok & CondEx}} & flagw_raw;

  assign ImmSrc  = Op;
  assign RegSrc  = {(Op == 2'b01), (Op == 2'b10)};
  assign State   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized and directed checks of multicycle_controller against an instruction-level model
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       CondEx;
  logic       PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA, NoWrite;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int n_checks = 0;
  int n_fail   = 0;
  int step     = 0;

  int st_tr[8], regw_tr[8], memw_tr[8], pcw_tr[8], irw_tr[8], flagw_tr[8];
  int rs_tr[8], adr_tr[8], srcb_tr[8], aluc_tr[8], nw_tr[8];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .CondEx(CondEx),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemW(MemW), .IRWrite(IRWrite), .RegW(RegW),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl), .FlagW(FlagW), .NoWrite(NoWrite),
    .State(State)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction length in cycles, FETCH to FETCH
  function automatic int seq_len(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b01:   return f[0] ? 5 : 4;
      2'b00:   return 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  // State code visited at a given step of an instruction
  function automatic int seq_state(input logic [1:0] op, input logic [5:0] f, input int s);
    int ldr_seq[5] = '{0, 1, 2, 3, 4};
    int str_seq[4] = '{0, 1, 2, 5};
    if (s < 2) return s;
    case (op)
      2'b01:   return f[0] ? ldr_seq[s] : str_seq[s];
      2'b00:   return (s == 2) ? (f[5] ? 7 : 6) : 8;
      default: return 9;
    endcase
  endfunction

  // Compare every output against what the current instruction step requires
  task automatic check_cycle();
    bit ldr, str, dp, br, fetch, decode, exec, wb_alu, wb_mem, memrd, memwr, adrc, brc;
    bit cmp, regwrite, suppress, live;
    logic [3:0] cmd;
    int exp_alu, exp_flag, raw;
    ldr    = (Op == 2'b01) && Funct[0];
    str    = (Op == 2'b01) && !Funct[0];
    dp     = (Op == 2'b00);
    br     = (Op == 2'b10);
    fetch  = (step == 0);
    decode = (step == 1);
    exec   = dp && step == 2;
    wb_alu = dp && step == 3;
    wb_mem = ldr && step == 4;
    memrd  = ldr && step == 3;
    memwr  = str && step == 3;
    adrc   = (ldr || str) && step == 2;
    brc    = br && step == 2;
    cmd    = Funct[4:1];
    cmp    = (cmd == 4'b1010);
    live   = !reset;

    exp_alu = 0;
    if (exec) begin
      case (cmd)
        4'b0010, 4'b1010: exp_alu = 1;
        4'b0000:          exp_alu = 2;
        4'b1100:          exp_alu = 3;
        default:          exp_alu = 0;
      endcase
    end
    raw = cmp ? 3 : (Funct[0] ? (((cmd == 4'b0100) || (cmd == 4'b0010)) ? 3 : 2) : 0);
    exp_flag = (exec && CondEx && live) ? raw : 0;

    regwrite = wb_alu || wb_mem;
    suppress = wb_alu && cmp;

    chk("State", State, seq_state(Op, Funct, step));
    chk("IRWrite", IRWrite, fetch && live);
    chk("PCWrite", PCWrite, live && (fetch || (brc && CondEx) ||
                                     (regwrite && CondEx && !suppress && Rd == 4'd15)));
    chk("RegW", RegW, live && regwrite && CondEx && !suppress);
    chk("MemW", MemW, live && memwr && CondEx);
    chk("AdrSrc", AdrSrc, memrd || memwr);
    chk("ResultSrc", ResultSrc, (fetch || decode || brc) ? 2 : (wb_mem ? 1 : 0));
    chk("ALUSrcA", ALUSrcA, fetch || decode);
    chk("ALUSrcB", ALUSrcB, (fetch || decode) ? 2 : ((adrc || (exec && Funct[5]) || brc) ? 1 : 0));
    chk("ALUControl", ALUControl, exp_alu);
    chk("FlagW", FlagW, exp_flag);
    chk("NoWrite", NoWrite, exec && cmp);
    chk("ImmSrc", ImmSrc, Op);
    chk("RegSrc", RegSrc, {Op == 2'b01, Op == 2'b10});
  endtask

  task automatic record(input int k);
    st_tr[k] = State;      regw_tr[k] = RegW;     memw_tr[k] = MemW;
    pcw_tr[k] = PCWrite;   irw_tr[k] = IRWrite;   flagw_tr[k] = FlagW;
    rs_tr[k] = ResultSrc;  adr_tr[k] = AdrSrc;    srcb_tr[k] = ALUSrcB;
    aluc_tr[k] = ALUControl; nw_tr[k] = NoWrite;
  endtask

  // Cross one rising edge and move the model to the step the DUT must now be in
  task automatic advance();
    bit r;
    int len;
    r   = reset;
    len = seq_len(Op, Funct);
    @(posedge clk);
    #1;
    if (r) step = 0;
    else begin
      step++;
      if (step >= len) step = 0;
    end
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input logic ce);
    int len;
    chk("instr_starts_at_fetch", step, 0);
    Op = op; Funct = f; Rd = rd; CondEx = ce;
    len = seq_len(op, f);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check_cycle();
      record(k);
      advance();
    end
  endtask

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; CondEx = 1'b1;
    @(posedge clk); #1; step = 0;
    @(negedge clk);
    chk("reset_state", State, 0);
    chk("reset_irwrite", IRWrite, 0);
    chk("reset_pcwrite", PCWrite, 0);
    check_cycle();
    advance();
    reset = 1'b0;

    // LDR
    run_instr(2'b01, 6'b011001, 4'd2, 1'b1);
    chk("first_fetch_irwrite", irw_tr[0], 1);
    chk("first_fetch_pcwrite", pcw_tr[0], 1);
    chk("ldr_states", (st_tr[0] << 16) | (st_tr[1] << 12) | (st_tr[2] << 8) | (st_tr[3] << 4) | st_tr[4], 'h01234);
    chk("ldr_regw", (regw_tr[0] << 4) | (regw_tr[1] << 3) | (regw_tr[2] << 2) | (regw_tr[3] << 1) | regw_tr[4], 1);
    chk("ldr_memwb_resultsrc", rs_tr[4], 1);

    // STR
    run_instr(2'b01, 6'b011000, 4'd2, 1'b1);
    chk("str_states", (st_tr[0] << 12) | (st_tr[1] << 8) | (st_tr[2] << 4) | st_tr[3], 'h0125);
    chk("str_memw", (memw_tr[0] << 3) | (memw_tr[1] << 2) | (memw_tr[2] << 1) | memw_tr[3], 1);
    chk("str_adrsrc", adr_tr[3], 1);

    // ADDS immediate, condition true then false
    run_instr(2'b00, 6'b101001, 4'd3, 1'b1);
    chk("adds_state", st_tr[2], 7);
    chk("adds_srcb", srcb_tr[2], 1);
    chk("adds_aluctl", aluc_tr[2], 0);
    chk("adds_flagw", flagw_tr[2], 3);
    chk("adds_regw", regw_tr[3], 1);
    run_instr(2'b00, 6'b101001, 4'd3, 1'b0);
    chk("adds_nc_flagw", flagw_tr[2], 0);
    chk("adds_nc_regw", regw_tr[3], 0);

    // CMP
    run_instr(2'b00, 6'b010101, 4'd15, 1'b1);
    chk("cmp_state", st_tr[2], 6);
    chk("cmp_aluctl", aluc_tr[2], 1);
    chk("cmp_flagw", flagw_tr[2], 3);
    chk("cmp_nowrite", nw_tr[2], 1);
    chk("cmp_regw", regw_tr[3], 0);
    chk("cmp_pcwrite", pcw_tr[3], 0);

    // Branch, and ADD to PC
    run_instr(2'b10, 6'b000000, 4'd0, 1'b0);
    chk("b_nc_pcwrite", pcw_tr[2], 0);
    run_instr(2'b10, 6'b000000, 4'd0, 1'b1);
    chk("b_pcwrite", pcw_tr[2], 1);
    run_instr(2'b00, 6'b001000, 4'd15, 1'b1);
    chk("addpc_regw", regw_tr[3], 1);
    chk("addpc_pcwrite", pcw_tr[3], 1);

    // Reset during MEMWR, held for two more cycles
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd1; CondEx = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check_cycle(); advance();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rst_memwr_state", State, 5);
    chk("rst_memwr_memw", MemW, 0);
    check_cycle(); advance();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_hold_state", State, 0);
      check_cycle(); advance();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_irwrite", IRWrite, 1);
    chk("post_rst_pcwrite", PCWrite, 1);
    check_cycle(); advance();
    // finish the STR already under way
    while (step != 0) begin
      @(negedge clk); check_cycle(); advance();
    end

    // Randomized instruction stream with occasional resets and per-cycle CondEx
    for (int c = 0; c < 3000; c++) begin
      if (step == 0) begin
        Op    = 2'($urandom_range(0, 3));
        Funct = 6'($urandom);
        Rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      end
      CondEx = 1'($urandom);
      reset  = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      check_cycle();
      advance();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
